// File: rtl/i2osp.sv
// i2osp -- integer-to-octet-string primitive for the RSA datapath.
//
// Converts a WIDTH-bit integer into a big-endian octet string of x_len
// octets, streamed most significant octet first, one per valid/ready
// handshake. Requests with x_len == 0 or x_len > MAX_LEN are rejected with a
// one-cycle error pulse.
//
// Optional feature macro: I2OSP_RANGE_CHECK_EN
//   defined   : a CHECK cycle rejects x >= 256^x_len (PKCS#1 "integer too
//               large"); first octet appears two cycles after accept.
//   undefined : no range check, high octets are silently truncated; first
//               octet appears one cycle after accept.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   valid    in   request strobe, sampled while ready=1
//   ready    out  idle, accepting a request
//   x        in   WIDTH-bit integer, captured on accept
//   x_len    in   requested octet count, captured on accept
//   o_valid  out  o_byte holds a valid octet
//   o_ready  in   downstream accepts the octet
//   o_byte   out  current octet
//   o_last   out  final octet of the string
//   error    out  one-cycle pulse on a rejected request
module i2osp #(
  parameter int WIDTH   = 2048,
  parameter int MAX_LEN = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] x,
  input  logic [8:0]       x_len,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [7:0]       o_byte,
  output logic             o_last,
  output logic             error
);

  localparam int KW = $clog2(MAX_LEN);
  localparam int LW = KW + 3;
  localparam logic [8:0] MAX_LEN_V = 9'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SEND  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [8:0]       r_k;

  logic             w_len_bad;
  logic [8:0]       w_k_in;
  logic [8:0]       w_k_dec;
  logic [LW-1:0]    w_dec_lo;
  logic [7:0]       w_next_byte;

  assign w_len_bad   = (x_len == 9'd0) || (x_len > MAX_LEN_V);
  assign w_k_in      = x_len - 9'd1;
  assign w_k_dec     = r_k - 9'd1;
  // Octet k of the captured integer sits at bits [8k+7:8k].
  assign w_dec_lo    = {w_k_dec[KW-1:0], 3'b000};
  assign w_next_byte = r_x[w_dec_lo +: 8];

`ifdef I2OSP_RANGE_CHECK_EN
  // The mask register marks every bit at or above 8*x_len, so the CHECK
  // cycle is a plain AND-reduce; the mask itself carries the captured length.
  logic [WIDTH-1:0] r_mask;
  logic             w_too_big;
  logic [LW-1:0]    w_cur_lo;
  logic [7:0]       w_cur_byte;

  assign w_too_big  = |(r_x & r_mask);
  assign w_cur_lo   = {r_k[KW-1:0], 3'b000};
  assign w_cur_byte = r_x[w_cur_lo +: 8];
`else
  // Without the CHECK cycle the first octet is taken straight from the input.
  logic [LW-1:0]    w_in_lo;
  logic [7:0]       w_in_byte;

  assign w_in_lo   = {w_k_in[KW-1:0], 3'b000};
  assign w_in_byte = x[w_in_lo +: 8];
`endif

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_k     <= 9'd0;
      ready   <= 1'b1;
      o_valid <= 1'b0;
      o_byte  <= 8'h00;
      o_last  <= 1'b0;
      error   <= 1'b0;
`ifdef I2OSP_RANGE_CHECK_EN
      r_mask  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          error <= 1'b0;
          if (valid) begin
            r_x   <= x;
            r_k   <= w_k_in;
            ready <= 1'b0;
`ifdef I2OSP_RANGE_CHECK_EN
            r_mask <= {WIDTH{1'b1}} << {x_len, 3'b000};
`endif
            if (w_len_bad) begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end else begin
`ifdef I2OSP_RANGE_CHECK_EN
              r_state <= S_CHECK;
`else
              r_state <= S_SEND;
              o_valid <= 1'b1;
              o_byte  <= w_in_byte;
              o_last  <= (w_k_in == 9'd0);
`endif
            end
          end
        end
        S_CHECK: begin
`ifdef I2OSP_RANGE_CHECK_EN
          if (w_too_big) begin
            r_state <= S_ERR;
            error   <= 1'b1;
          end else begin
            r_state <= S_SEND;
            o_valid <= 1'b1;
            o_byte  <= w_cur_byte;
            o_last  <= (r_k == 9'd0);
          end
`else
          r_state <= S_IDLE;
          ready   <= 1'b1;
`endif
        end
        S_SEND: begin
          // Without a handshake every output register simply holds.
          if (o_ready) begin
            if (r_k == 9'd0) begin
              r_state <= S_IDLE;
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              ready   <= 1'b1;
            end else begin
              r_k    <= w_k_dec;
              o_byte <= w_next_byte;
              o_last <= (w_k_dec == 9'd0);
            end
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
          error   <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
          o_valid <= 1'b0;
          o_last  <= 1'b0;
          error   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2osp.sv
// Directed self-checking bench for i2osp. Follows the DUT build: define
// I2OSP_RANGE_CHECK_EN for both or neither.
module tb_i2osp;

  localparam int WIDTH = 2048;
`ifdef I2OSP_RANGE_CHECK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             reset;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] x;
  logic [8:0]       x_len;
  logic             o_valid;
  logic             o_ready;
  logic [7:0]       o_byte;
  logic             o_last;
  logic             error;

  int checks;
  int errors;

  i2osp #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .ready   (ready),
    .x       (x),
    .x_len   (x_len),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_byte  (o_byte),
    .o_last  (o_last),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns in cycle A+1 (just after the accept edge).
  task automatic send_req(input logic [WIDTH-1:0] xv, input logic [8:0] len);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout ready=%b required 1", ready);
    end
    valid = 1'b1;
    x     = xv;
    x_len = len;
    step();
    valid = 1'b0;
    x     = '0;
    x_len = 9'd0;
  endtask

  // Full-throughput stream; exp holds the hand-computed octets, last in [7:0].
  task automatic run_stream(input string name, input logic [WIDTH-1:0] xv,
                            input logic [8:0] len, input logic [63:0] exp);
    logic [7:0] eb;
    o_ready = 1'b1;
    send_req(xv, len);
    if (LAT == 2) begin
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_check_cycle o_valid=%b required 0", name, o_valid);
      end
      step();
    end
    for (int i = 0; i < int'(len); i++) begin
      eb = exp[8*(int'(len)-1-i) +: 8];
      checks++;
      if (o_valid !== 1'b1 || o_byte !== eb || o_last !== (i == int'(len) - 1)) begin
        errors++;
        $display("FAIL %s_octet%0d valid=%b byte=%h last=%b required 1 %h %b",
                 name, i, o_valid, o_byte, o_last, eb, (i == int'(len) - 1));
      end
      step();
    end
    checks++;
    if (o_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_end valid=%b ready=%b required 0 1", name, o_valid, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b required 1", ready); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got %b required 0", o_valid); end
    checks++;
    if (o_last !== 1'b0) begin errors++; $display("FAIL rst_o_last got %b required 0", o_last); end
    checks++;
    if (o_byte !== 8'h00) begin errors++; $display("FAIL rst_o_byte got %h required 00", o_byte); end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b required 0", error); end
  endtask

  task automatic test_basic();
    run_stream("basic", 2048'h030201, 9'd3, 64'h030201);
  endtask

  task automatic test_padding();
    run_stream("pad", 2048'h030201, 9'd5, 64'h0000030201);
  endtask

  task automatic test_range();
`ifdef I2OSP_RANGE_CHECK_EN
    o_ready = 1'b1;
    send_req(2048'h030201, 9'd2);
    checks++;
    if (error !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_a1 error=%b valid=%b required 0 0", error, o_valid);
    end
    step();
    checks++;
    if (error !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_a2 error=%b valid=%b required 1 0", error, o_valid);
    end
    step();
    checks++;
    if (error !== 1'b0 || ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_after error=%b ready=%b valid=%b required 0 1 0",
               error, ready, o_valid);
    end
`else
    run_stream("trunc", 2048'h030201, 9'd2, 64'h0201);
`endif
  endtask

  task automatic test_full_width();
    int bad;
    int last_at;
    int lasts;
    bad = 0;
    last_at = -1;
    lasts = 0;
    o_ready = 1'b1;
    send_req({WIDTH{1'b1}}, 9'd256);
    for (int i = 1; i < LAT; i++) step();
    for (int i = 0; i < 256; i++) begin
      if (o_valid !== 1'b1 || o_byte !== 8'hFF) bad++;
      if (o_last === 1'b1) begin
        lasts++;
        last_at = i;
      end
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_octets bad=%0d required 0", bad); end
    checks++;
    if (lasts != 1 || last_at != 255) begin
      errors++;
      $display("FAIL full_last count=%0d at=%0d required 1 255", lasts, last_at);
    end
    checks++;
    if (o_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL full_end valid=%b ready=%b required 0 1", o_valid, ready);
    end
  endtask

  task automatic test_len_fault();
    logic [8:0] lens [2];
    lens[0] = 9'd0;
    lens[1] = 9'd257;
    for (int j = 0; j < 2; j++) begin
      send_req({WIDTH{1'b1}}, lens[j]);
      checks++;
      if (error !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL lenfault%0d_a1 error=%b valid=%b required 1 0", lens[j], error, o_valid);
      end
      step();
      checks++;
      if (error !== 1'b0 || ready !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL lenfault%0d_after error=%b ready=%b valid=%b required 0 1 0",
                 lens[j], error, ready, o_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    o_ready = 1'b1;
    send_req(2048'h0A0B0C, 9'd3);
    for (int i = 1; i < LAT; i++) step();
    checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h0A || o_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_first valid=%b byte=%h last=%b required 1 0a 0", o_valid, o_byte, o_last);
    end
    step();
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_byte !== 8'h0B || o_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d valid=%b byte=%h last=%b required 1 0b 0",
                 i, o_valid, o_byte, o_last);
      end
      step();
    end
    o_ready = 1'b1;
    checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h0B || o_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_release valid=%b byte=%h last=%b required 1 0b 0", o_valid, o_byte, o_last);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h0C || o_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_last valid=%b byte=%h last=%b required 1 0c 1", o_valid, o_byte, o_last);
    end
    step();
    checks++;
    if (o_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end valid=%b ready=%b required 0 1", o_valid, ready);
    end
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b1;
    send_req(2048'h11223344, 9'd4);
    for (int i = 1; i < LAT; i++) step();
    checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h11) begin
      errors++;
      $display("FAIL rm_oct0 valid=%b byte=%h required 1 11", o_valid, o_byte);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_byte !== 8'h22) begin
      errors++;
      $display("FAIL rm_oct1 valid=%b byte=%h required 1 22", o_valid, o_byte);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || error !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_reset valid=%b last=%b error=%b ready=%b required 0 0 0 1",
               o_valid, o_last, error, ready);
    end
    run_stream("rm_new", 2048'h55, 9'd1, 64'h55);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    valid   = 1'b0;
    x       = '0;
    x_len   = 9'd0;
    o_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_padding();
    test_range();
    test_full_width();
    test_len_fault();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
